// File: rtl/rsc_enc_param_pkg.sv
// Shared constants for the parametrised RSC encoder.
// FSM state codes, default polynomials and memory-order limits.
package rsc_pkg;

    typedef logic [1:0] fsm_t;

    localparam fsm_t IDLE = 2'd0;
    localparam fsm_t RUN  = 2'd1;
    localparam fsm_t TAIL = 2'd2;

    localparam int MEM_MIN = 2;
    localparam int MEM_MAX = 6;
    localparam int DEF_MEM = 3;

    // 13 octal feedback, 15 octal feedforward
    localparam logic [3:0] DEF_G_FB = 4'b1101;
    localparam logic [3:0] DEF_G_FF = 4'b1011;

endpackage

// File: rtl/rsc_enc_param_if.sv
// Input and output valid/ready streams of the RSC encoder.
// master drives the input stream and sinks the output; slave is the encoder.
interface rsc_enc_param_if #(
    parameter int DATA_W = 16
);

    logic              in_valid_i;
    logic              in_ready_o;
    logic              in_last_i;
    logic [DATA_W-1:0] data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] data_sys;
    logic [DATA_W-1:0] data_enc;
    logic              out_last_o;
    logic              out_tail_o;

    modport master (
        output in_valid_i, in_last_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_sys, data_enc,
        input  out_last_o, out_tail_o
    );

    modport slave (
        input  in_valid_i, in_last_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, data_sys, data_enc,
        output out_last_o, out_tail_o
    );

endinterface

// File: rtl/rsc_trellis_word.sv
// Combinational RSC trellis unrolled over one word (DATA_W steps)
// or over a MEM-step termination sequence when tail is high.
module rsc_trellis_word
    import rsc_pkg::*;
#(
    parameter int             DATA_W = 16,
    parameter int             MEM    = DEF_MEM,
    parameter logic [MEM:0]   G_FB   = DEF_G_FB,
    parameter logic [MEM:0]   G_FF   = DEF_G_FF
) (
    input  logic [MEM-1:0]    state,
    input  logic [DATA_W-1:0] bits,
    input  logic              tail,
    output logic [DATA_W-1:0] sys,
    output logic [DATA_W-1:0] parity,
    output logic [MEM-1:0]    next_state
);

    logic [MEM-1:0] s;
    logic           fb;
    logic           u;
    logic           a;
    logic           p;

    always_comb begin
        s      = state;
        sys    = '0;
        parity = '0;
        fb     = 1'b0;
        u      = 1'b0;
        a      = 1'b0;
        p      = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            if (!tail || k < MEM) begin
                fb = 1'b0;
                for (int i = 1; i <= MEM; i++)
                    fb = fb ^ (G_FB[i] & s[i-1]);
                // in tail mode u cancels the feedback so a is 0
                u = tail ? fb : bits[k];
                a = u ^ fb;
                p = G_FF[0] & a;
                for (int i = 1; i <= MEM; i++)
                    p = p ^ (G_FF[i] & s[i-1]);
                sys[k]    = u;
                parity[k] = p;
                s         = {s[MEM-2:0], a};
            end
        end
        next_state = s;
    end

endmodule

// File: rtl/rsc_enc_param.sv
// Parametrised RSC encoder, one word per cycle, registered output stage.
// Define RSC_TERM_EN to emit a trellis termination (tail) beat per block.
module rsc_enc_param
    import rsc_pkg::*;
#(
    parameter int           DATA_W = 16,
    parameter int           MEM    = DEF_MEM,
    parameter logic [MEM:0] G_FB   = DEF_G_FB,
    parameter logic [MEM:0] G_FF   = DEF_G_FF
) (
    input logic             clk_p_i,
    input logic             reset_p_i,
    rsc_enc_param_if.slave  bus
);

    fsm_t              fsm;
    logic [MEM-1:0]    st;
    logic [MEM-1:0]    cur_st;
    logic [MEM-1:0]    nxt_st;
    logic [DATA_W-1:0] t_sys;
    logic [DATA_W-1:0] t_par;
    logic              in_tail;
    logic              slot_free;
    logic              accept;
    logic              tail_go;

    logic              vld;
    logic [DATA_W-1:0] sys_q;
    logic [DATA_W-1:0] enc_q;
    logic              last_q;
    logic              tail_q;

`ifdef RSC_TERM_EN
    assign in_tail = (fsm == TAIL);
`else
    assign in_tail = 1'b0;
`endif

    assign slot_free     = !vld || bus.out_ready_i;
    assign bus.in_ready_o = !in_tail && slot_free;
    assign accept        = bus.in_valid_i && bus.in_ready_o;
    assign tail_go       = in_tail && slot_free;
    // every block starts from the all-zero state
    assign cur_st        = (fsm == IDLE) ? '0 : st;

    rsc_trellis_word #(
        .DATA_W (DATA_W),
        .MEM    (MEM),
        .G_FB   (G_FB),
        .G_FF   (G_FF)
    ) u_trellis (
        .state      (cur_st),
        .bits       (bus.data_i),
        .tail       (in_tail),
        .sys        (t_sys),
        .parity     (t_par),
        .next_state (nxt_st)
    );

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            fsm    <= IDLE;
            st     <= '0;
            vld    <= 1'b0;
            sys_q  <= '0;
            enc_q  <= '0;
            last_q <= 1'b0;
            tail_q <= 1'b0;
        end else if (accept) begin
            vld    <= 1'b1;
            sys_q  <= t_sys;
            enc_q  <= t_par;
            tail_q <= 1'b0;
`ifdef RSC_TERM_EN
            last_q <= 1'b0;
            st     <= nxt_st;
            fsm    <= bus.in_last_i ? TAIL : RUN;
`else
            last_q <= bus.in_last_i;
            st     <= bus.in_last_i ? '0 : nxt_st;
            fsm    <= bus.in_last_i ? IDLE : RUN;
`endif
        end else if (tail_go) begin
            vld    <= 1'b1;
            sys_q  <= t_sys;
            enc_q  <= t_par;
            last_q <= 1'b1;
            tail_q <= 1'b1;
            st     <= '0;
            fsm    <= IDLE;
        end else if (bus.out_ready_i) begin
            vld    <= 1'b0;
        end
    end

    assign bus.out_valid_o = vld;
    assign bus.data_sys    = sys_q;
    assign bus.data_enc    = enc_q;
    assign bus.out_last_o  = last_q;
    assign bus.out_tail_o  = tail_q;

endmodule

// File: tb/tb_rsc_enc_param.sv
// Self-checking bench for rsc_enc_param against a polynomial-level model.
// Expectations follow RSC_TERM_EN the same way the design does.
module tb_rsc_enc_param;

    localparam int DW  = 16;
    localparam int MEM = 3;
    localparam logic [MEM:0] G_FB = 4'b1101;
    localparam logic [MEM:0] G_FF = 4'b1011;
`ifdef RSC_TERM_EN
    localparam bit TERM = 1'b1;
`else
    localparam bit TERM = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] sys;
        logic [DW-1:0] enc;
        logic          last;
        logic          tail;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rsc_enc_param_if #(.DATA_W(DW)) bus ();

    rsc_enc_param #(
        .DATA_W (DW),
        .MEM    (MEM),
        .G_FB   (G_FB),
        .G_FF   (G_FF)
    ) dut (
        .clk_p_i   (clk),
        .reset_p_i (rst),
        .bus       (bus)
    );

    int total  = 0;
    int passed = 0;

    beat_t          exp_q[$];
    logic [MEM-1:0] mst;

    // Feedback is the parity of state & G_FB[MEM:1]; parity output is
    // the parity of {state, a} & G_FF, i.e. polynomial products over GF(2).
    function automatic void model_accept(input logic [DW-1:0] d, input logic l);
        logic [DW-1:0] par;
        logic [DW-1:0] tsys;
        logic [DW-1:0] tpar;
        logic          a;
        par  = '0;
        tsys = '0;
        tpar = '0;
        for (int k = 0; k < DW; k++) begin
            a      = d[k] ^ (^(mst & G_FB[MEM:1]));
            par[k] = ^({mst, a} & G_FF);
            mst    = {mst[MEM-2:0], a};
        end
        if (TERM) begin
            exp_q.push_back({d, par, 1'b0, 1'b0});
            if (l) begin
                for (int k = 0; k < MEM; k++) begin
                    tsys[k] = ^(mst & G_FB[MEM:1]);
                    tpar[k] = ^({mst, 1'b0} & G_FF);
                    mst     = {mst[MEM-2:0], 1'b0};
                end
                exp_q.push_back({tsys, tpar, 1'b1, 1'b1});
                mst = '0;
            end
        end else begin
            exp_q.push_back({d, par, l, 1'b0});
            if (l) mst = '0;
        end
    endfunction

    task automatic idle();
        bus.in_valid_i  = 1'b0;
        bus.in_last_i   = 1'b0;
        bus.data_i      = '0;
        bus.out_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        beat_t obs;
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        obs = {bus.data_sys, bus.data_enc, bus.out_last_o, bus.out_tail_o};
        total++;
        if (bus.out_valid_o !== 1'b0)
            $display("FAIL reset_valid: got %b want 0", bus.out_valid_o);
        else passed++;
        total++;
        if (bus.in_ready_o !== 1'b1)
            $display("FAIL reset_ready: got %b want 1", bus.in_ready_o);
        else passed++;
        total++;
        if (obs !== '0)
            $display("FAIL reset_outputs: got %h want 0", obs);
        else passed++;
    endtask

    task automatic test_zero();
        beat_t obs;
        beat_t e;
        int    sent;
        int    got;
        int    cyc;
        int    nb;
        sent = 0;
        got  = 0;
        cyc  = 0;
        nb   = TERM ? 5 : 4;
        idle();
        while (got < nb && cyc < 40) begin
            @(negedge clk);
            cyc++;
            obs = {bus.data_sys, bus.data_enc, bus.out_last_o, bus.out_tail_o};
            if (bus.out_valid_o) begin
                e = {16'h0000, 16'h0000, got == nb - 1, TERM && got == nb - 1};
                total++;
                if (obs !== e)
                    $display("FAIL zero_beat%0d: got %h want %h", got, obs, e);
                else passed++;
                got++;
            end
            if (sent < 4 && bus.in_ready_o) begin
                bus.in_valid_i = 1'b1;
                bus.data_i     = '0;
                bus.in_last_i  = (sent == 3);
                sent++;
            end else begin
                bus.in_valid_i = 1'b0;
            end
        end
        total++;
        if (got != nb)
            $display("FAIL zero_count: got %0d beats want %0d", got, nb);
        else passed++;
        idle();
    endtask

    task automatic test_single();
        beat_t obs;
        beat_t e1;
        beat_t e2;
        e1 = {16'h0001, 16'hA74F, ~TERM, 1'b0};
        e2 = {16'h0003, 16'h0002, 1'b1, 1'b1};
        for (int r = 0; r < 2; r++) begin
            idle();
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.data_i     = 16'h0001;
            bus.in_last_i  = 1'b1;
            @(negedge clk);
            idle();
            obs = {bus.data_sys, bus.data_enc, bus.out_last_o, bus.out_tail_o};
            total++;
            if ({bus.out_valid_o, obs} !== {1'b1, e1})
                $display("FAIL single_data%0d: got %b_%h want 1_%h",
                         r, bus.out_valid_o, obs, e1);
            else passed++;
            total++;
            if (bus.in_ready_o !== ~TERM)
                $display("FAIL single_ready%0d: got %b want %b",
                         r, bus.in_ready_o, ~TERM);
            else passed++;
`ifdef RSC_TERM_EN
            @(negedge clk);
            obs = {bus.data_sys, bus.data_enc, bus.out_last_o, bus.out_tail_o};
            total++;
            if ({bus.out_valid_o, obs} !== {1'b1, e2})
                $display("FAIL single_tail%0d: got %b_%h want 1_%h",
                         r, bus.out_valid_o, obs, e2);
            else passed++;
`endif
            @(negedge clk);
            total++;
            if (bus.out_valid_o !== 1'b0)
                $display("FAIL single_end%0d: got %b want 0", r, bus.out_valid_o);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW:0] stim[$];
        beat_t       obs;
        beat_t       held;
        bit          hv;
        int          cyc;
        hv   = 1'b0;
        held = '0;
        cyc  = 0;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 8; w++)
                stim.push_back({w == 7, DW'($urandom)});
        exp_q.delete();
        mst = '0;
        while ((stim.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            obs = {bus.data_sys, bus.data_enc, bus.out_last_o, bus.out_tail_o};
            if (hv) begin
                total++;
                if ({bus.out_valid_o, obs} !== {1'b1, held})
                    $display("FAIL stall_hold: got %b_%h want 1_%h",
                             bus.out_valid_o, obs, held);
                else passed++;
            end
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            if (stim.size() > 0 && $urandom_range(0, 4) != 0) begin
                bus.in_valid_i = 1'b1;
                {bus.in_last_i, bus.data_i} = stim[0];
            end else begin
                bus.in_valid_i = 1'b0;
                bus.in_last_i  = 1'($urandom_range(0, 1));
                bus.data_i     = DW'($urandom);
            end
            #1;
            if (bus.out_valid_o && bus.out_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra: got %h want no beat", obs);
                end else begin
                    if (obs !== exp_q[0])
                        $display("FAIL rand_beat: got %h want %h", obs, exp_q[0]);
                    else passed++;
                    void'(exp_q.pop_front());
                end
            end
            hv   = bus.out_valid_o && !bus.out_ready_i;
            held = obs;
            if (bus.in_valid_i && bus.in_ready_o) begin
                model_accept(bus.data_i, bus.in_last_i);
                void'(stim.pop_front());
            end
        end
        total++;
        if (stim.size() != 0 || exp_q.size() != 0)
            $display("FAIL rand_timeout: got %0d/%0d left want 0/0",
                     stim.size(), exp_q.size());
        else passed++;
        idle();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] words[5];
        beat_t         obs;
        int            sent;
        int            cyc;
        idle();
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.data_i     = DW'($urandom);
            bus.in_last_i  = 1'b0;
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid_o !== 1'b0)
            $display("FAIL midrst_valid: got %b want 0", bus.out_valid_o);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid_o !== 1'b0)
            $display("FAIL midrst_no_tail: got %b want 0", bus.out_valid_o);
        else passed++;
        exp_q.delete();
        mst = '0;
        for (int w = 0; w < 5; w++) words[w] = DW'($urandom);
        sent = 0;
        cyc  = 0;
        while ((sent < 5 || exp_q.size() > 0) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            obs = {bus.data_sys, bus.data_enc, bus.out_last_o, bus.out_tail_o};
            if (bus.out_valid_o) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL midrst_extra: got %h want no beat", obs);
                end else begin
                    if (obs !== exp_q[0])
                        $display("FAIL midrst_beat: got %h want %h", obs, exp_q[0]);
                    else passed++;
                    void'(exp_q.pop_front());
                end
            end
            if (sent < 5 && bus.in_ready_o) begin
                bus.in_valid_i = 1'b1;
                bus.data_i     = words[sent];
                bus.in_last_i  = (sent == 4);
                model_accept(words[sent], sent == 4);
                sent++;
            end else begin
                bus.in_valid_i = 1'b0;
            end
        end
        total++;
        if (sent != 5 || exp_q.size() != 0)
            $display("FAIL midrst_timeout: got %0d sent %0d left want 5 sent 0 left",
                     sent, exp_q.size());
        else passed++;
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mst = '0;
        idle();
        test_reset();
        test_zero();
        test_single();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
